// File: rtl/strided_fetch.sv
// Read-issue stage behind a strided address generator: issues SRAM reads on credit,
// collects fixed-latency returns into an output FIFO, and drains through valid/ready.
module strided_fetch #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int MEM_LAT    = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int PTR_W     = $clog2(FIFO_DEPTH),
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
   localparam int INF_W     = $clog2(MEM_LAT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       total,
   input  logic [ADDR_W-1:0] addr_in,
   output logic              step,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state,
   output logic [CNT_W-1:0]  dbg_fifo_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Stream handshake: a word transfers on any cycle where out_valid=1 and out_ready=1;
   // out_valid never depends on out_ready, and out_data is held until the transfer.

   state_t              state, state_nxt;
   logic [31:0]         remaining;
   logic [MEM_LAT-1:0]  vpipe;
   logic [INF_W-1:0]    inflight;
   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    fifo_count;
   logic                done_r, done_nxt;
   logic                issue, push, pop, credit_ok;

   // Credits use registered occupancy only, so a pop in this cycle frees no slot yet.
   assign credit_ok = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
   assign push      = vpipe[MEM_LAT-1];
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (total != 32'd0) state_nxt = ST_RUN;
               else                done_nxt  = 1'b1;
            end
         end
         ST_RUN: begin
            if ((remaining != 32'd0) && credit_ok) begin
               issue = 1'b1;
               if (remaining == 32'd1) state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Leave as soon as the final word is leaving, so done follows the last pop by one cycle.
            if ((inflight == '0) &&
                ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         done_r    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= done_nxt;
         if ((state == ST_IDLE) && start) remaining <= total;
         else if (issue)                  remaining <= remaining - 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpipe    <= '0;
         inflight <= '0;
      end else begin
         vpipe[0] <= issue;
         for (int i = 1; i < MEM_LAT; i++) vpipe[i] <= vpipe[i-1];
         case ({issue, push})
            2'b10:   inflight <= inflight + INF_W'(1);
            2'b01:   inflight <= inflight - INF_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign step           = issue;
   assign mem_ren        = issue;
   assign mem_addr       = issue ? addr_in : '0;
   assign out_data       = out_valid ? fifo_mem[rd_ptr] : '0;
   assign busy           = (state != ST_IDLE);
   assign done           = done_r;
   assign dbg_state      = state;
   assign dbg_fifo_count = fifo_count;

endmodule

// File: tb/tb_strided_fetch.sv
// Directed bench for strided_fetch: default instance (MEM_LAT=2, depth 4) for the
// functional scenarios, plus a MEM_LAT=3/depth 8 instance for random backpressure.
module tb_strided_fetch;

   localparam int LAT_A = 2, DEPTH_A = 4, LAT_B = 3, DEPTH_B = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, gen_clr;
   int   checks = 0, failures = 0;
   logic [15:0] exp_q[$];

   // instance A signals
   logic        start, out_ready, step, mem_ren, out_valid, busy, done;
   logic [31:0] total;
   logic [15:0] addr_in, mem_addr, mem_rdata, out_data;
   logic [1:0]  dbg_state;
   logic [2:0]  dbg_fifo_count;

   // instance B signals
   logic        b_start, b_out_ready, b_step, b_mem_ren, b_out_valid, b_busy, b_done;
   logic [31:0] b_total;
   logic [15:0] b_addr_in, b_mem_addr, b_mem_rdata, b_out_data;
   logic [1:0]  b_dbg_state;
   logic [3:0]  b_dbg_fifo_count;

   strided_fetch #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT_A), .FIFO_DEPTH(DEPTH_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .total(total), .addr_in(addr_in),
      .step(step), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .done(done), .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count));

   strided_fetch #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT_B), .FIFO_DEPTH(DEPTH_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .total(b_total), .addr_in(b_addr_in),
      .step(b_step), .mem_ren(b_mem_ren), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy),
      .done(b_done), .dbg_state(b_dbg_state), .dbg_fifo_count(b_dbg_fifo_count));

   // generator model for A: 2-D nest, x fastest
   int gen_idx = 0, gen_off = 0, gen_xmax = 1, gen_xs = 0, gen_ys = 0;
   assign addr_in = 16'(gen_off + (gen_idx % gen_xmax) * gen_xs + (gen_idx / gen_xmax) * gen_ys);
   always @(posedge clk) begin
      if (gen_clr)   gen_idx <= 0;
      else if (step) gen_idx <= gen_idx + 1;
   end

   function automatic logic [15:0] gen_addr(int idx);
      return 16'(gen_off + (idx % gen_xmax) * gen_xs + (idx / gen_xmax) * gen_ys);
   endfunction

   // generator model for B: linear, stride 3 from 0x1000
   int b_idx = 0;
   assign b_addr_in = 16'(32'h1000 + b_idx * 3);
   always @(posedge clk) begin
      if (gen_clr)     b_idx <= 0;
      else if (b_step) b_idx <= b_idx + 1;
   end

   // SRAM models: data = addr ^ 0xA5A5, delivered MEM_LAT cycles after the read
   logic [15:0] a_d [LAT_A];
   logic [15:0] b_d [LAT_B];
   always @(posedge clk) begin
      a_d[0] <= mem_addr ^ 16'hA5A5;
      for (int i = 1; i < LAT_A; i++) a_d[i] <= a_d[i-1];
      b_d[0] <= b_mem_addr ^ 16'hA5A5;
      for (int i = 1; i < LAT_B; i++) b_d[i] <= b_d[i-1];
   end
   assign mem_rdata   = a_d[LAT_A-1];
   assign b_mem_rdata = b_d[LAT_B-1];

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic gen_setup(int off, int xmax, int xs, int ys);
      gen_off = off; gen_xmax = xmax; gen_xs = xs; gen_ys = ys;
      gen_clr = 1'b1;
      tick();
      gen_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; total = '0; out_ready = 1'b0; gen_clr = 1'b1;
      b_start = 1'b0; b_total = '0; b_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({step, mem_ren, out_valid, busy, done} !== 5'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=00000", {step, mem_ren, out_valid, busy, done});
      end
      checks++;
      if (mem_addr !== 16'h0 || out_data !== 16'h0) begin
         failures++; $display("FAIL reset_data mem_addr=%h out_data=%h exp=0", mem_addr, out_data);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
      gen_clr = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_state !== 2'd0 || busy !== 1'b0 || dbg_fifo_count !== 3'd0) begin
         failures++; $display("FAIL reset_idle state=%0d busy=%b count=%0d exp=0", dbg_state, busy, dbg_fifo_count);
      end
      tick();
   endtask

   task automatic test_streaming();
      logic [15:0] exp_addr [6];
      logic [15:0] exp_w;
      int cyc = 0, n_step = 0, n_pop = 0, last_pop = -10, first_valid = -1;
      bit fin = 0;
      exp_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0110, 16'h0111, 16'h0112};
      gen_setup(32'h100, 3, 1, 32'h10);
      exp_q = '{16'hA4A5, 16'hA4A4, 16'hA4A7, 16'hA4B5, 16'hA4B4, 16'hA4B7};
      start = 1'b1; total = 32'd6; out_ready = 1'b1;
      for (int k = 0; k < 40 && !fin; k++) begin
         @(negedge clk);
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (step) begin
            checks++;
            if (n_step >= 6) begin
               failures++; $display("FAIL stream_extra_step cyc=%0d", cyc);
            end else if (cyc != n_step + 1 || mem_addr !== exp_addr[n_step] || mem_ren !== 1'b1) begin
               failures++; $display("FAIL stream_issue cyc=%0d addr=%h ren=%b exp_cyc=%0d exp_addr=%h",
                                    cyc, mem_addr, mem_ren, n_step + 1, exp_addr[n_step]);
            end
            n_step++;
         end
         if (out_valid && out_ready) begin
            checks++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (out_data !== exp_w) begin
               failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_w);
            end
            n_pop++; last_pop = cyc;
         end
         if (done) begin
            checks++;
            if (cyc != last_pop + 1 || busy !== 1'b0) begin
               failures++; $display("FAIL stream_done cyc=%0d busy=%b exp_cyc=%0d exp_busy=0", cyc, busy, last_pop + 1);
            end
            fin = 1;
         end
         tick();
         start = 1'b0; cyc++;
      end
      checks++;
      if (!fin || n_step != 6 || n_pop != 6 || first_valid != LAT_A + 2) begin
         failures++; $display("FAIL stream_summary done=%0d steps=%0d pops=%0d first_valid=%0d exp=1/6/6/%0d",
                              fin, n_step, n_pop, first_valid, LAT_A + 2);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_w, held;
      int n_ren = 0, n_pop = 0;
      bit fin = 0, unstable = 0, seen = 0;
      gen_setup(32'h200, 5, 2, 32'h40);
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(gen_addr(i) ^ 16'hA5A5);
      start = 1'b1; total = 32'd10; out_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (mem_ren) begin
            checks++;
            if (mem_addr !== gen_addr(n_ren)) begin
               failures++; $display("FAIL bp_addr n=%0d got=%h exp=%h", n_ren, mem_addr, gen_addr(n_ren));
            end
            n_ren++;
         end
         if (out_valid) begin
            if (seen && out_data !== held) unstable = 1;
            held = out_data; seen = 1;
         end
         tick();
         start = 1'b0;
      end
      checks++;
      if (n_ren != 4 || out_valid !== 1'b1 || out_data !== exp_q[0] || unstable) begin
         failures++; $display("FAIL bp_stall reads=%0d valid=%b data=%h unstable=%0d exp=4/1/%h/0",
                              n_ren, out_valid, out_data, unstable, exp_q[0]);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 60 && !fin; k++) begin
         @(negedge clk);
         if (mem_ren) begin
            checks++;
            if (mem_addr !== gen_addr(n_ren)) begin
               failures++; $display("FAIL bp_addr n=%0d got=%h exp=%h", n_ren, mem_addr, gen_addr(n_ren));
            end
            n_ren++;
         end
         if (out_valid && out_ready) begin
            checks++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (out_data !== exp_w) begin
               failures++; $display("FAIL bp_data n=%0d got=%h exp=%h", n_pop, out_data, exp_w);
            end
            n_pop++;
         end
         if (done) fin = 1;
         tick();
      end
      checks++;
      if (!fin || n_ren != 10 || n_pop != 10 || exp_q.size() != 0) begin
         failures++; $display("FAIL bp_summary done=%0d reads=%0d pops=%0d left=%0d exp=1/10/10/0",
                              fin, n_ren, n_pop, exp_q.size());
      end
   endtask

   task automatic test_zero_length();
      int cyc = 0, n_done = 0, done_cyc = -1;
      bit issued = 0, was_busy = 0;
      start = 1'b1; total = 32'd0; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (step || mem_ren) issued = 1;
         if (busy) was_busy = 1;
         if (done) begin n_done++; done_cyc = cyc; end
         tick();
         start = 1'b0; cyc++;
      end
      checks++;
      if (issued) begin failures++; $display("FAIL zero_issue got=1 exp=0"); end
      checks++;
      if (was_busy) begin failures++; $display("FAIL zero_busy got=1 exp=0"); end
      checks++;
      if (n_done != 1 || done_cyc != 1) begin
         failures++; $display("FAIL zero_done pulses=%0d cyc=%0d exp=1/1", n_done, done_cyc);
      end
   endtask

   task automatic test_start_while_busy();
      logic [15:0] exp_w;
      int cyc = 0, n_step = 0, n_pop = 0, n_done = 0;
      gen_setup(32'h300, 4, 1, 32'h8);
      exp_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back(gen_addr(i) ^ 16'hA5A5);
      start = 1'b1; total = 32'd3; out_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (step) n_step++;
         if (out_valid && out_ready) begin
            checks++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (out_data !== exp_w) begin
               failures++; $display("FAIL swb_data n=%0d got=%h exp=%h", n_pop, out_data, exp_w);
            end
            n_pop++;
         end
         if (done) n_done++;
         tick();
         cyc++;
         start = (cyc == 2 || cyc == 3);
         total = (cyc >= 2) ? 32'd7 : 32'd3;
      end
      checks++;
      if (n_step != 3 || n_pop != 3 || n_done != 1 || dbg_state !== 2'd0) begin
         failures++; $display("FAIL swb_summary steps=%0d pops=%0d dones=%0d state=%0d exp=3/3/1/0",
                              n_step, n_pop, n_done, dbg_state);
      end
   endtask

   task automatic test_reset_mid_run();
      bit stale = 0;
      gen_setup(32'h400, 8, 1, 0);
      start = 1'b1; total = 32'd8; out_ready = 1'b1;
      repeat (3) begin tick(); start = 1'b0; end
      checks++;
      if (mem_ren !== 1'b1 || mem_addr !== 16'h0402) begin
         failures++; $display("FAIL rst_third_issue ren=%b addr=%h exp=1/0402", mem_ren, mem_addr);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({step, mem_ren, out_valid, busy, done} !== 5'b0 || mem_addr !== 16'h0 || out_data !== 16'h0) begin
         failures++; $display("FAIL rst_outputs ctrl=%b addr=%h data=%h exp=0",
                              {step, mem_ren, out_valid, busy, done}, mem_addr, out_data);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid || busy || step || done || dbg_state !== 2'd0) stale = 1;
      end
      checks++;
      if (stale) begin failures++; $display("FAIL rst_stale got=activity exp=idle"); end
      tick();
   endtask

   task automatic test_random_backpressure();
      logic [15:0] exp_w;
      int n_step = 0, n_pop = 0, max_cnt = 0;
      bit fin = 0;
      gen_clr = 1'b1; tick(); gen_clr = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(16'(32'h1000 + i * 3) ^ 16'hA5A5);
      b_start = 1'b1; b_total = 32'd64; b_out_ready = 1'b0;
      for (int k = 0; k < 3000 && !fin; k++) begin
         @(negedge clk);
         if (int'(b_dbg_fifo_count) > max_cnt) max_cnt = int'(b_dbg_fifo_count);
         if (b_step) begin
            checks++;
            if (b_mem_addr !== 16'(32'h1000 + n_step * 3) || b_mem_ren !== 1'b1) begin
               failures++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n_step, b_mem_addr, 16'(32'h1000 + n_step * 3));
            end
            n_step++;
         end
         if (b_out_valid && b_out_ready) begin
            checks++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (b_out_data !== exp_w) begin
               failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n_pop, b_out_data, exp_w);
            end
            n_pop++;
         end
         if (b_done) fin = 1;
         tick();
         b_start = 1'b0;
         b_out_ready = 1'($urandom_range(0, 1));
      end
      checks++;
      if (max_cnt > DEPTH_B) begin failures++; $display("FAIL rnd_fifo_count max=%0d limit=%0d", max_cnt, DEPTH_B); end
      checks++;
      if (!fin || n_step != 64 || n_pop != 64 || exp_q.size() != 0) begin
         failures++; $display("FAIL rnd_summary done=%0d steps=%0d pops=%0d left=%0d exp=1/64/64/0",
                              fin, n_step, n_pop, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_zero_length();
      test_start_while_busy();
      test_reset_mid_run();
      test_random_backpressure();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
